dram_req_arbiter: RTL and testbench
===================================

Name: dram_req_arbiter

Overview:
- Shares the single bridge request channel (toward the pseudo DRAM) between two requesters:
  - port 0: the BEV engine (drink make/supply/check).
  - port 1: a maintenance/refill agent.
- Round-robin arbitration, exactly one outstanding transaction at a time.
- A response watchdog returns an error to the requester if the bridge never answers.
- Sits between the BEV-side engines and the bridge, at the top level next to the pseudo DRAM.

Parameters:
- ADDR_W, 8, box index width (256 entries).
- DATA_W, 64, DRAM word width.
- TIMEOUT_CYC, 1000, maximum WAIT cycles before the error response.
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid[1:0]  in  2  per-requester request pending; held until accepted.
- req_addr0 / req_addr1  in  ADDR_W  box index.
- req_r_wb[1:0]  in  2  1 = read, 0 = write.
- req_wdata0 / req_wdata1  in  DATA_W  write data; ignored for reads.
- req_ready[1:0]  out  2  accept strobe, one-hot or zero.
- rsp_valid[1:0]  out  2  one-cycle response strobe, one-hot or zero.
- rsp_data  out  DATA_W  read data; shared bus, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- c_in_valid  out  1  bridge request strobe.
- c_addr  out  ADDR_W  bridge address.
- c_r_wb  out  1  bridge direction.
- c_data_w  out  DATA_W  bridge write data.
- c_out_valid  in  1  bridge completion strobe.
- c_data_r  in  DATA_W  bridge read data.
- busy  out  1  high in every state except IDLE.
- late_drop  out  1  sticky: a c_out_valid arrived outside WAIT; cleared only by reset.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE, rr_ptr = 0, watchdog = 0.
  - Latched addr/data/dir/owner cleared to 0.
  - All outputs 0, including late_drop.
  - An in-flight transaction is discarded: no rsp_valid, no c_in_valid reissue.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational from req_valid and rr_ptr.
  - Only one requester valid: that one wins.
  - Both valid: requester rr_ptr wins.
  - On the edge where req_ready[g] = 1:
    - latch addr/r_wb/wdata of g and owner = g;
    - rr_ptr <= ~g;
    - go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - c_in_valid = 1 for exactly one cycle, with c_addr/c_r_wb/c_data_w from the latches.
  - watchdog <= 0; go to WAIT.
  - c_addr/c_r_wb/c_data_w read 0 whenever c_in_valid = 0.
- WAIT:
  - c_out_valid = 1: latch c_data_r (reads) or 0 (writes), err = 0, go to RESP.
  - Else if watchdog == TIMEOUT_CYC-1: data = 0, err = 1, go to RESP.
  - Else watchdog += 1.
  - c_out_valid together with the final watchdog cycle: the response wins, err = 0.
- RESP:
  - rsp_valid[owner] = 1 for one cycle, with rsp_data and rsp_err from the latches.
  - Go to IDLE; a new grant is possible in the very next cycle.
  - rsp_data and rsp_err are 0 when no rsp_valid is asserted.
- Latency:
  - Accept edge -> c_in_valid in the next cycle.
  - c_out_valid in cycle N -> rsp_valid in cycle N+1.
  - Minimum request-to-response with a 1-cycle bridge: accept T, issue T+1, bridge response T+2, rsp T+3.
- late_drop: c_out_valid seen in IDLE/ISSUE/RESP (e.g. after a timeout) sets late_drop. The strobe is otherwise ignored and must not produce a response.
- Fairness:
  - Under continuous contention, grants strictly alternate 0,1,0,1…
  - A requester dropping req_valid before acceptance is legal; nothing is latched.

Test Plan:
- Single read: req_valid = 01, addr = 8'h05, r_wb = 1 → req_ready[0] at T, c_in_valid at T+1 with c_addr = 05; bridge returns 64'h0123_4567_89AB_CDEF at T+4 → rsp_valid = 01 at T+5, data matches, rsp_err = 0.
- Write from port 1: addr = 8'hFF, wdata = 64'hDEAD_BEEF_0000_0001 → c_data_w matches, c_r_wb = 0; rsp_valid = 10 with rsp_data = 0.
- Contention: both valid, held for 4 transactions → grant order 0,1,0,1; req_ready never 11; c_in_valid never while busy in WAIT.
- Timeout: TIMEOUT_CYC = 16, bridge silent → rsp_valid after exactly 16 WAIT cycles with rsp_err = 1, data 0; later c_out_valid sets late_drop = 1, no rsp_valid.
- Boundary: c_out_valid on the 16th WAIT cycle (TIMEOUT_CYC = 16) → rsp_err = 0, data passed through.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0, state IDLE, rr_ptr = 0; subsequent c_out_valid sets late_drop and produces no response; a new request proceeds normally.

Source files
------------

// File: rtl/dram_req_arbiter.sv
// Two-port round-robin arbiter in front of the pseudo-DRAM bridge.
// One transaction in flight; a watchdog answers with an error if the bridge stays silent.
module dram_req_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [1:0]        req_r_wb,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              c_in_valid,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_r_wb,
  output logic [DATA_W-1:0] c_data_w,
  input  logic              c_out_valid,
  input  logic [DATA_W-1:0] c_data_r,
  output logic              busy,
  output logic              late_drop
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              dir_q, dir_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic              late_q, late_d;
  logic              gnt;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    wd_d      = wd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    dir_d     = dir_q;
    owner_d   = owner_q;
    err_d     = err_q;
    late_d    = late_q;
    req_ready = '0;
    gnt       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rr_q names the preferred port only when both are requesting
        unique case (req_valid)
          2'b01:   req_ready = 2'b01;
          2'b10:   req_ready = 2'b10;
          2'b11:   req_ready = rr_q ? 2'b10 : 2'b01;
          default: req_ready = '0;
        endcase
        if (|req_ready) begin
          gnt     = req_ready[1];
          owner_d = gnt;
          rr_d    = ~gnt;
          addr_d  = gnt ? req_addr1 : req_addr0;
          wdata_d = gnt ? req_wdata1 : req_wdata0;
          dir_d   = req_r_wb[gnt];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a bridge answer in the final watchdog cycle still counts as success
        if (c_out_valid) begin
          rdata_d = dir_q ? c_data_r : '0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WD_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (c_out_valid && (state_q != S_WAIT)) late_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      wd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dir_q   <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dir_q   <= dir_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    c_in_valid = (state_q == S_ISSUE);
    c_addr     = c_in_valid ? addr_q  : '0;
    c_r_wb     = c_in_valid ? dir_q   : 1'b0;
    c_data_w   = c_in_valid ? wdata_q : '0;
    rsp_valid  = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_data   = (state_q == S_RESP) ? rdata_q : '0;
    rsp_err    = (state_q == S_RESP) ? err_q : 1'b0;
    busy       = (state_q != S_IDLE);
    late_drop  = late_q;
  end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Transaction-level bench for dram_req_arbiter: directed cases plus random traffic
// checked against a grant/latency/response model derived from the arbitration rules.
module tb_dram_req_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [7:0]  req_addr0 = '0, req_addr1 = '0;
  logic [1:0]  req_r_wb = '0;
  logic [63:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err, c_in_valid, c_r_wb, busy, late_drop;
  logic [7:0]  c_addr;
  logic [63:0] c_data_w;
  logic        c_out_valid = 1'b0;
  logic [63:0] c_data_r = '0;

  int n_cmp = 0;
  int n_err = 0;
  int pref = 0;
  bit exp_late = 1'b0;

  dram_req_arbiter #(.ADDR_W(8), .DATA_W(64), .TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_r_wb(req_r_wb),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .c_in_valid(c_in_valid), .c_addr(c_addr), .c_r_wb(c_r_wb), .c_data_w(c_data_w),
    .c_out_valid(c_out_valid), .c_data_r(c_data_r), .busy(busy), .late_drop(late_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic at_check();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: vld at accept time, bridge answers in WAIT cycle dly
  // (dly >= TO means silent), optional stray bridge strobe after a timeout.
  task automatic txn(input logic [1:0] vld, input int dly, input bit late);
    int g;
    bit resp;
    int nw;
    logic [63:0] exp_data;
    at_drive();
    req_valid   = vld;
    c_out_valid = 1'b0;
    at_check();
    g = (vld == 2'b01) ? 0 : (vld == 2'b10) ? 1 : pref;
    chk("grant", 64'(req_ready), 64'(2'b01 << g));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("late_drop", 64'(late_drop), 64'(exp_late));
    pref = 1 - g;

    at_drive();
    req_valid[g] = 1'b0;
    at_check();
    chk("issue_valid", 64'(c_in_valid), 64'd1);
    chk("issue_addr", 64'(c_addr), 64'(g ? req_addr1 : req_addr0));
    chk("issue_dir", 64'(c_r_wb), 64'(req_r_wb[g]));
    if (!req_r_wb[g]) chk("issue_wdata", c_data_w, g ? req_wdata1 : req_wdata0);
    chk("issue_ready", 64'(req_ready), 64'd0);
    chk("issue_busy", 64'(busy), 64'd1);

    resp = (dly < TO);
    nw   = resp ? dly + 1 : TO;
    for (int i = 0; i < nw; i++) begin
      at_drive();
      c_out_valid = resp && (i == dly);
      at_check();
      chk("wait_cinv", 64'(c_in_valid), 64'd0);
      chk("wait_caddr", 64'(c_addr), 64'd0);
      chk("wait_rsp", 64'(rsp_valid), 64'd0);
      chk("wait_err", 64'(rsp_err), 64'd0);
      chk("wait_data", rsp_data, 64'd0);
      chk("wait_ready", 64'(req_ready), 64'd0);
    end

    at_drive();
    c_out_valid = 1'b0;
    at_check();
    exp_data = (resp && req_r_wb[g]) ? c_data_r : 64'd0;
    chk("rsp_valid", 64'(rsp_valid), 64'(2'b01 << g));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", 64'(rsp_err), 64'(!resp));
    chk("rsp_ready", 64'(req_ready), 64'd0);

    if (late && !resp) begin
      at_drive();
      req_valid   = '0;
      c_out_valid = 1'b1;
      at_check();
      chk("late_rsp", 64'(rsp_valid), 64'd0);
      exp_late = 1'b1;
      at_drive();
      c_out_valid = 1'b0;
      at_check();
      chk("late_set", 64'(late_drop), 64'd1);
      chk("late_norsp", 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    at_check();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_cinv", 64'(c_in_valid), 64'd0);
    chk("rst_late", 64'(late_drop), 64'd0);

    // single read, bridge answers three cycles after issue
    req_addr0 = 8'h05; req_r_wb = 2'b01; c_data_r = 64'h0123_4567_89AB_CDEF;
    txn(2'b01, 2, 1'b0);
    // write from port 1
    req_addr1 = 8'hFF; req_wdata1 = 64'hDEAD_BEEF_0000_0001; req_r_wb = 2'b00;
    txn(2'b10, 0, 1'b0);
    // contention: expect strict alternation starting at port 0
    req_r_wb = 2'b11; req_addr0 = 8'h11; req_addr1 = 8'h22;
    for (int k = 0; k < 4; k++) txn(2'b11, k, 1'b0);
    // timeout followed by a stray bridge strobe
    txn(2'b01, TO + 3, 1'b1);
    // answer on the last watchdog cycle wins over the timeout
    c_data_r = 64'hCAFE_F00D_1234_5678;
    txn(2'b10, TO - 1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      req_addr0  = 8'($urandom);
      req_addr1  = 8'($urandom);
      req_wdata0 = {$urandom, $urandom};
      req_wdata1 = {$urandom, $urandom};
      req_r_wb   = 2'($urandom);
      c_data_r   = {$urandom, $urandom};
      txn(2'($urandom_range(1, 3)), int'($urandom_range(0, TO + 3)), 1'($urandom));
    end

    // reset in the middle of WAIT after a port-0 grant
    at_drive();
    req_valid = 2'b01; req_r_wb = 2'b01; req_addr0 = 8'h3C;
    at_check();
    chk("mid_grant", 64'(req_ready), 64'd1);
    at_drive(); req_valid = '0;
    at_drive();
    at_drive(); rst_n = 1'b0;
    at_drive(); rst_n = 1'b1;
    at_check();
    pref = 0;
    exp_late = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_rsp", 64'(rsp_valid), 64'd0);
    chk("mrst_cinv", 64'(c_in_valid), 64'd0);
    chk("mrst_caddr", 64'(c_addr), 64'd0);
    chk("mrst_late", 64'(late_drop), 64'd0);
    at_drive(); c_out_valid = 1'b1;
    at_check();
    chk("mrst_norsp", 64'(rsp_valid), 64'd0);
    at_drive(); c_out_valid = 1'b0;
    at_check();
    chk("mrst_lateset", 64'(late_drop), 64'd1);
    exp_late = 1'b1;
    req_r_wb = 2'b11; c_data_r = 64'h0000_0000_5555_AAAA;
    txn(2'b11, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
